keypad_scanner: RTL and testbench

//   Scans a 4x4 matrix keypad (rows: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D) by driving one column low at a time
//   and sensing active-low rows. Debounces press and release and emits the 4-bit key code consumed by the
//   7-segment key display decoder. Code = {row[1:0], col[1:0]}; code 0000='A' ... 1111='*'.

---
 rtl/keypad_scanner.sv | 173 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with press/release debouncing.
//
// Drives one column low at a time, senses active-low rows through a 2-FF
// synchronizer and, once a key has been stable for DEBOUNCE_TICKS scan ticks,
// publishes its code {row, col} with a one-cycle key_valid pulse.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   row_n[3:0]   in   keypad rows, active-low, asynchronous to clk
//   col_n[3:0]   out  column drive, exactly one bit low
//   key_code     out  last accepted key {r[1:0], c[1:0]}
//   key_valid    out  one-cycle pulse when key_code updates
//   key_pressed  out  high while the accepted key is held
module keypad_scanner #(
    parameter int unsigned SCAN_TICKS     = 10000,
    parameter int unsigned DEBOUNCE_TICKS = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_pressed
);

    localparam int unsigned TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int unsigned DW = $clog2(DEBOUNCE_TICKS + 1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      row_meta_q, row_s_q;
    logic [TW-1:0]   tick_cnt_q;
    logic            tick;
    logic [1:0]      col_q, col_d;
    logic [1:0]      row_q, row_d;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic [3:0]      code_q, code_d;
    logic            valid_q, valid_d;
    logic            pressed_q, pressed_d;
    logic            row_any;
    logic            row_hit;
    logic            cnt_done;

    // Lowest-index row currently pulled low.
    function automatic logic [1:0] lowest_low(input logic [3:0] r);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!r[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    // Row synchronizer; idle rows read high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q <= 4'hF;
            row_s_q    <= 4'hF;
        end else begin
            row_meta_q <= row_n;
            row_s_q    <= row_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + TW'(1);
        end
    end

    assign tick     = (tick_cnt_q == TW'(SCAN_TICKS - 1));
    assign row_any  = ~&row_s_q;
    assign row_hit  = ~row_s_q[row_q];
    assign cnt_done = ((cnt_q + DW'(1)) == DW'(DEBOUNCE_TICKS));

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        pressed_d = pressed_q;
        if (tick) begin
            unique case (state_q)
                ST_SCAN: begin
                    if (row_any) begin
                        row_d   = lowest_low(row_s_q);
                        cnt_d   = '0;
                        state_d = ST_DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (row_hit) begin
                        if (cnt_done) begin
                            code_d    = {row_q, col_q};
                            valid_d   = 1'b1;
                            pressed_d = 1'b1;
                            state_d   = ST_HELD;
                        end else begin
                            cnt_d = cnt_q + DW'(1);
                        end
                    end else begin
                        // Bounce before acceptance: resume scanning on the same column.
                        state_d = ST_SCAN;
                    end
                end
                ST_HELD: begin
                    if (!row_hit) begin
                        cnt_d   = '0;
                        state_d = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!row_hit) begin
                        if (cnt_done) begin
                            pressed_d = 1'b0;
                            col_d     = col_q + 2'd1;
                            state_d   = ST_SCAN;
                        end else begin
                            cnt_d = cnt_q + DW'(1);
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: state_d = ST_SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_SCAN;
            col_q     <= 2'd0;
            row_q     <= 2'd0;
            cnt_q     <= '0;
            code_q    <= 4'd0;
            valid_q   <= 1'b0;
            pressed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            pressed_q <= pressed_d;
        end
    end

    assign col_n       = ~(4'b0001 << col_q);
    assign key_code    = code_q;
    assign key_valid   = valid_q;
    assign key_pressed = pressed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with SCAN_TICKS=4,
// DEBOUNCE_TICKS=3 and a behavioural keypad that shorts pressed keys' rows
// to their driven column. Sample index k counts negedges since reset release;
// scan ticks act on posedges 4, 8, 12, ...
module tb_keypad_scanner;

    logic        clk;
    logic        rst_n;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_pressed;

    logic [15:0] keys;     // bit r*4+c = key at row r, column c pressed
    int          k;
    int          vcnt;
    int          checks;
    int          errors;

    keypad_scanner #(
        .SCAN_TICKS    (4),
        .DEBOUNCE_TICKS(3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .row_n      (row_n),
        .col_n      (col_n),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_pressed(key_pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        k++;
        if (key_valid === 1'b1) vcnt++;
    endtask

    task automatic goto(input int t);
        while (k < t) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        k     = 0;
        vcnt  = 0;
    endtask

    task automatic test_reset();
        logic [3:0] exp_col;
        keys  = 16'h0000;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (col_n !== 4'b1110) begin errors++; $display("FAIL reset_col: got %b expected 1110", col_n); end
        checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL reset_code: got %b expected 0000", key_code); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
        checks++; if (key_pressed !== 1'b0) begin errors++; $display("FAIL reset_pressed: got %b expected 0", key_pressed); end
        rst_n = 1'b1;
        k     = 0;
        vcnt  = 0;
        for (int i = 0; i < 20; i++) begin
            goto(i);
            exp_col = ~(4'b0001 << ((i / 4) % 4));
            checks++;
            if (col_n !== exp_col) begin
                errors++;
                $display("FAIL scan_col k=%0d: got %b expected %b", i, col_n, exp_col);
            end
        end
        checks++; if (vcnt !== 0) begin errors++; $display("FAIL idle_valid: got %0d pulses expected 0", vcnt); end
        checks++; if (key_pressed !== 1'b0) begin errors++; $display("FAIL idle_pressed: got %b expected 0", key_pressed); end
    endtask

    task automatic test_hold_5();
        keys = 16'h0040;   // '5': r1 c2
        do_reset();
        goto(23);
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL h5_early: got %b expected 0", key_valid); end
        goto(24);
        checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL h5_valid: got %b expected 1", key_valid); end
        checks++; if (key_code !== 4'b0110) begin errors++; $display("FAIL h5_code: got %b expected 0110", key_code); end
        checks++; if (key_pressed !== 1'b1) begin errors++; $display("FAIL h5_pressed: got %b expected 1", key_pressed); end
        goto(25);
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL h5_pulse: got %b expected 0", key_valid); end
        goto(400);
        checks++; if (vcnt !== 1) begin errors++; $display("FAIL h5_count: got %0d pulses expected 1", vcnt); end
        checks++; if (key_code !== 4'b0110) begin errors++; $display("FAIL h5_hold_code: got %b expected 0110", key_code); end
        checks++; if (key_pressed !== 1'b1) begin errors++; $display("FAIL h5_hold_pressed: got %b expected 1", key_pressed); end
        checks++; if (col_n !== 4'b1011) begin errors++; $display("FAIL h5_col: got %b expected 1011", col_n); end
        keys = 16'h0000;
        goto(440);
        checks++; if (key_pressed !== 1'b0) begin errors++; $display("FAIL h5_release: got %b expected 0", key_pressed); end
        checks++; if (key_code !== 4'b0110) begin errors++; $display("FAIL h5_kept_code: got %b expected 0110", key_code); end
    endtask

    task automatic test_short_press();
        keys = 16'h2000;   // '#': r3 c1
        do_reset();
        goto(13);
        keys = 16'h0000;
        goto(19);
        checks++; if (col_n !== 4'b1101) begin errors++; $display("FAIL sp_col_hold: got %b expected 1101", col_n); end
        goto(20);
        checks++; if (col_n !== 4'b1011) begin errors++; $display("FAIL sp_col_next: got %b expected 1011", col_n); end
        goto(40);
        checks++; if (vcnt !== 0) begin errors++; $display("FAIL sp_valid: got %0d pulses expected 0", vcnt); end
        checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL sp_code: got %b expected 0000", key_code); end
        checks++; if (key_pressed !== 1'b0) begin errors++; $display("FAIL sp_pressed: got %b expected 0", key_pressed); end
    endtask

    task automatic test_glitch_release();
        keys = 16'h0001;   // 'A': r0 c0
        do_reset();
        goto(16);
        checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL gr_valid: got %b expected 1", key_valid); end
        checks++; if (key_code !== 4'b0000) begin errors++; $display("FAIL gr_code: got %b expected 0000", key_code); end
        goto(17); keys = 16'h0000;
        goto(25); keys = 16'h0001;   // one-tick glitch low
        goto(29); keys = 16'h0000;
        goto(33); keys = 16'h0001;   // second one-tick glitch
        goto(37); keys = 16'h0000;
        goto(47);
        checks++; if (key_pressed !== 1'b1) begin errors++; $display("FAIL gr_still: got %b expected 1", key_pressed); end
        checks++; if (col_n !== 4'b1110) begin errors++; $display("FAIL gr_col_lock: got %b expected 1110", col_n); end
        goto(48);
        checks++; if (key_pressed !== 1'b0) begin errors++; $display("FAIL gr_fall: got %b expected 0", key_pressed); end
        checks++; if (col_n !== 4'b1101) begin errors++; $display("FAIL gr_col_next: got %b expected 1101", col_n); end
        goto(60);
        checks++; if (vcnt !== 1) begin errors++; $display("FAIL gr_count: got %0d pulses expected 1", vcnt); end
    endtask

    task automatic test_multi();
        keys = 16'h1001;   // 'A' r0 c0 and 'D' r3 c0
        do_reset();
        goto(16);
        checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL mk_valid: got %b expected 1", key_valid); end
        checks++; if (key_code !== 4'b0000) begin errors++; $display("FAIL mk_code: got %b expected 0000", key_code); end
        goto(20);
        keys = 16'h9001;   // add '*' r3 c3 during HELD
        goto(100);
        checks++; if (vcnt !== 1) begin errors++; $display("FAIL mk_count: got %0d pulses expected 1", vcnt); end
        checks++; if (key_code !== 4'b0000) begin errors++; $display("FAIL mk_hold_code: got %b expected 0000", key_code); end
        checks++; if (key_pressed !== 1'b1) begin errors++; $display("FAIL mk_pressed: got %b expected 1", key_pressed); end
        checks++; if (col_n !== 4'b1110) begin errors++; $display("FAIL mk_col: got %b expected 1110", col_n); end
        keys = 16'h0000;
        goto(140);
        checks++; if (key_pressed !== 1'b0) begin errors++; $display("FAIL mk_release: got %b expected 0", key_pressed); end
    endtask

    task automatic test_reset_mid();
        keys = 16'h0040;   // '5' first, so key_code is non-zero
        do_reset();
        goto(25); keys = 16'h0000;
        goto(41); keys = 16'h0800;   // '7': r2 c3
        goto(49);
        checks++; if (col_n !== 4'b0111) begin errors++; $display("FAIL rm_pre_col: got %b expected 0111", col_n); end
        checks++; if (key_code !== 4'b0110) begin errors++; $display("FAIL rm_pre_code: got %b expected 0110", key_code); end
        checks++; if (key_pressed !== 1'b0) begin errors++; $display("FAIL rm_pre_pressed: got %b expected 0", key_pressed); end
        goto(50);
        rst_n = 1'b0;
        #1;
        checks++; if (col_n !== 4'b1110) begin errors++; $display("FAIL rm_col: got %b expected 1110", col_n); end
        checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL rm_code: got %b expected 0000", key_code); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b expected 0", key_valid); end
        checks++; if (key_pressed !== 1'b0) begin errors++; $display("FAIL rm_pressed: got %b expected 0", key_pressed); end
        vcnt = 0;
        for (int i = 0; i < 6; i++) step();
        checks++; if (vcnt !== 0) begin errors++; $display("FAIL rm_no_pulse: got %0d pulses expected 0", vcnt); end
        keys  = 16'h0000;
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        k      = 0;
        vcnt   = 0;
        keys   = 16'h0000;
        rst_n  = 1'b0;
        test_reset();
        test_hold_5();
        test_short_press();
        test_glitch_release();
        test_multi();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
